// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Bursts of up to MAX_BURST beats per grant; never writes while wfull is high.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          w_clk,
   input  logic                          w_rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic [IDX_W-1:0]  pick_s;
   logic [IDX_W-1:0]  owner_nxt_s;
   logic              found_s;
   logic              accept_s;
   logic              burst_done_s;
   logic [NUM_REQ-1:0] ack_s;
   logic              winc_s;

   // Search upward from rr_ptr for the first active request, wrapping modulo NUM_REQ.
   always_comb begin
      int idx_v;
      found_s = 1'b0;
      pick_s  = '0;
      idx_v   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_v = int'(rr_ptr_q) + i;
         idx_v = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
         if (!found_s && req[IDX_W'(idx_v)]) begin
            found_s = 1'b1;
            pick_s  = IDX_W'(idx_v);
         end else begin
            found_s = found_s;
         end
      end
   end

   assign owner_nxt_s  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
   assign accept_s     = (state_q == OWN) & req[owner_q] & ~wfull;
   assign burst_done_s = ((beat_cnt_q + 4'd1) == 4'(MAX_BURST));

   // Write data mux selected by the current owner.
   always_comb begin
      wdata = req_data[0 +: DATA_WIDTH];
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner_q == IDX_W'(k)) begin
            wdata = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            wdata = wdata;
         end
      end
   end

   // Next-state and grant logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      ack_s      = '0;
      winc_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               owner_d    = pick_s;
               beat_cnt_d = 4'd0;
               state_d    = OWN;
            end else begin
               state_d    = IDLE;
            end
         end
         OWN: begin
            if (accept_s) begin
               ack_s[owner_q] = 1'b1;
               winc_s         = 1'b1;
               if (burst_done_s) begin
                  rr_ptr_d   = owner_nxt_s;
                  beat_cnt_d = 4'd0;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 4'd1;
               end
            end else if (!req[owner_q]) begin
               // Withdrawn request ends the burst early and still rotates priority.
               rr_ptr_d   = owner_nxt_s;
               beat_cnt_d = 4'd0;
               state_d    = IDLE;
            end else begin
               state_d    = OWN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign ack   = w_rst ? '0 : ack_s;
   assign winc  = winc_s & ~w_rst;
   assign owner = owner_q;
   assign busy  = (state_q == OWN);

endmodule
